// File: rtl/tmr_fault_monitor.sv
// Watches the three raw channels of a TMR voter against its voted output.
// Flags channels that persistently disagree, and flags a voter that disagrees with the raw majority.
module tmr_fault_monitor #(
    parameter int THRESH = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             x2,
    input  logic             x1,
    input  logic             x0,
    input  logic             y,
    output logic             y_q,
    output logic [2:0]       fault,
    output logic [CNT_W-1:0] err_cnt2,
    output logic [CNT_W-1:0] err_cnt1,
    output logic [CNT_W-1:0] err_cnt0,
    output logic             alarm,
    output logic             voter_err
);

    typedef enum logic [1:0] {
        OK      = 2'd0,
        SUSPECT = 2'd1,
        FAULTY  = 2'd2
    } state_t;

    localparam logic [3:0]       THRESH_C = 4'(THRESH);
    localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

    state_t           state_q [3];
    state_t           state_d [3];
    logic [3:0]       cnt_q   [3];
    logic [3:0]       cnt_d   [3];
    logic [CNT_W-1:0] err_q   [3];
    logic [CNT_W-1:0] err_d   [3];
    logic [2:0]       fault_d;
    logic             alarm_d;
    logic             voter_err_d;
    logic [2:0]       x;
    logic [2:0]       mis;
    logic             maj;

    assign x   = {x2, x1, x0};
    assign mis = en ? (x ^ {3{y}}) : 3'b000;
    assign maj = (x2 & x1) | (x2 & x0) | (x1 & x0);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            err_d[i]   = err_q[i];
            fault_d[i] = 1'b0;
            if (clr) begin
                state_d[i] = OK;
                cnt_d[i]   = 4'd0;
                err_d[i]   = '0;
            end else if (mis[i]) begin
                if (err_q[i] != ERR_MAX) begin
                    err_d[i] = err_q[i] + CNT_W'(1);
                end
                case (state_q[i])
                    OK: begin
                        state_d[i] = SUSPECT;
                        cnt_d[i]   = 4'd1;
                    end
                    SUSPECT: begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                        if (cnt_q[i] + 4'd1 == THRESH_C) begin
                            state_d[i] = FAULTY;
                        end
                    end
                    default: state_d[i] = FAULTY;
                endcase
            end else if (en && state_q[i] == SUSPECT) begin
                state_d[i] = OK;
                cnt_d[i]   = 4'd0;
            end
            fault_d[i] = (state_d[i] == FAULTY);
        end
        // alarm looks at next-state faults so it rises together with the second fault bit
        alarm_d     = (fault_d[2] & fault_d[1]) | (fault_d[2] & fault_d[0]) | (fault_d[1] & fault_d[0]);
        voter_err_d = clr ? 1'b0 : (voter_err | (en & (y != maj)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= OK;
                cnt_q[i]   <= 4'd0;
                err_q[i]   <= '0;
            end
            fault     <= 3'b000;
            alarm     <= 1'b0;
            voter_err <= 1'b0;
            y_q       <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                err_q[i]   <= err_d[i];
            end
            fault     <= fault_d;
            alarm     <= alarm_d;
            voter_err <= voter_err_d;
            if (en) begin
                y_q <= y;
            end
        end
    end

    assign err_cnt2 = err_q[2];
    assign err_cnt1 = err_q[1];
    assign err_cnt0 = err_q[0];

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed plus random bench for tmr_fault_monitor: a behavioural model queues expected outputs,
// which are popped and compared one cycle later. A second instance with CNT_W=2 checks saturation.
module tb_tmr_fault_monitor;

    localparam int THRESH = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       x2, x1, x0;
    logic       y;
    logic       y_q;
    logic [2:0] fault;
    logic [7:0] err_cnt2, err_cnt1, err_cnt0;
    logic       alarm;
    logic       voter_err;
    logic       s_y_q;
    logic [2:0] s_fault;
    logic [1:0] s_err_cnt2, s_err_cnt1, s_err_cnt0;
    logic       s_alarm;
    logic       s_voter_err;

    typedef struct packed {
        logic [2:0] fault;
        logic       alarm;
        logic       verr;
        logic       yq;
        logic [7:0] e2;
        logic [7:0] e1;
        logic [7:0] e0;
        logic [1:0] s0;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    int   m_cons   [3];
    bit   m_faulty [3];
    int   m_err    [3];
    bit   m_verr;
    bit   m_yq;

    tmr_fault_monitor #(.THRESH(THRESH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .x2(x2), .x1(x1), .x0(x0), .y(y),
        .y_q(y_q), .fault(fault),
        .err_cnt2(err_cnt2), .err_cnt1(err_cnt1), .err_cnt0(err_cnt0),
        .alarm(alarm), .voter_err(voter_err)
    );

    tmr_fault_monitor #(.THRESH(THRESH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .x2(x2), .x1(x1), .x0(x0), .y(y),
        .y_q(s_y_q), .fault(s_fault),
        .err_cnt2(s_err_cnt2), .err_cnt1(s_err_cnt1), .err_cnt0(s_err_cnt0),
        .alarm(s_alarm), .voter_err(s_voter_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic exp_t modelExpect();
        exp_t e;
        int   nf;
        nf = 0;
        for (int i = 0; i < 3; i++) begin
            e.fault[i] = m_faulty[i];
            nf += m_faulty[i] ? 1 : 0;
        end
        e.alarm = (nf >= 2);
        e.verr  = m_verr;
        e.yq    = m_yq;
        e.e2    = 8'(sat(m_err[2], 255));
        e.e1    = 8'(sat(m_err[1], 255));
        e.e0    = 8'(sat(m_err[0], 255));
        e.s0    = 2'(sat(m_err[0], 3));
        return e;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            m_cons[i]   = 0;
            m_faulty[i] = 1'b0;
            m_err[i]    = 0;
        end
        m_verr = 1'b0;
        m_yq   = 1'b0;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        cmp("fault",     32'(fault),      32'(e.fault));
        cmp("alarm",     32'(alarm),      32'(e.alarm));
        cmp("voter_err", 32'(voter_err),  32'(e.verr));
        cmp("y_q",       32'(y_q),        32'(e.yq));
        cmp("err_cnt2",  32'(err_cnt2),   32'(e.e2));
        cmp("err_cnt1",  32'(err_cnt1),   32'(e.e1));
        cmp("err_cnt0",  32'(err_cnt0),   32'(e.e0));
        cmp("sat_cnt0",  32'(s_err_cnt0), 32'(e.s0));
        cmp("sat_fault", 32'(s_fault),    32'(e.fault));
    endtask

    // One clock cycle: drive inputs, advance the model, then compare just after the edge.
    task automatic applyStimulus(input logic e_in, input logic c_in, input logic [2:0] xv, input logic yv);
        logic mj;
        en  = e_in;
        clr = c_in;
        {x2, x1, x0} = xv;
        y   = yv;
        mj  = (xv[2] & xv[1]) | (xv[2] & xv[0]) | (xv[1] & xv[0]);
        if (e_in) m_yq = yv;
        if (c_in) begin
            for (int i = 0; i < 3; i++) begin
                m_cons[i]   = 0;
                m_faulty[i] = 1'b0;
                m_err[i]    = 0;
            end
            m_verr = 1'b0;
        end else if (e_in) begin
            for (int i = 0; i < 3; i++) begin
                if (xv[i] != yv) begin
                    m_err[i]++;
                    if (!m_faulty[i]) begin
                        m_cons[i]++;
                        if (m_cons[i] >= THRESH) m_faulty[i] = 1'b1;
                    end
                end else if (!m_faulty[i]) begin
                    m_cons[i] = 0;
                end
            end
            if (yv != mj) m_verr = 1'b1;
        end
        sb.push_back(modelExpect());
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Asserts reset away from any edge and checks outputs before a clock can arrive.
    task automatic resetDut();
        en  = 1'b0;
        clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        sb.push_back(modelExpect());
        checkOutput();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic       re, rc;
        logic [2:0] rx;
        logic       ry;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        en       = 1'b0;
        clr      = 1'b0;
        {x2, x1, x0} = 3'b000;
        y        = 1'b0;
        modelReset();
        resetDut();

        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 3'b110, 1'b1);
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b011, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b111, 1'b1);

        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 3'b110, 1'b1);
        applyStimulus(1'b1, 1'b0, 3'b111, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 3'b110, 1'b1);
        applyStimulus(1'b0, 1'b0, 3'b111, 1'b1);
        applyStimulus(1'b1, 1'b0, 3'b110, 1'b1);

        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 3'b100, 1'b1);
        applyStimulus(1'b1, 1'b1, 3'b000, 1'b1);

        applyStimulus(1'b1, 1'b0, 3'b111, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b000, 1'b0);

        for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, 3'b001, 1'b0);
        applyStimulus(1'b1, 1'b1, 3'b001, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'b111, 1'b1);
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);

        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 3'b111, 1'b0);
        resetDut();
        applyStimulus(1'b1, 1'b0, 3'b110, 1'b1);

        for (int k = 0; k < 60; k++) begin
            re = ($urandom_range(0, 4) != 0);
            rc = re && ($urandom_range(0, 15) == 0);
            ry = 1'($urandom_range(0, 1));
            rx = {3{ry}};
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) rx[i] = ~ry;
            end
            applyStimulus(re, rc, rx, ry);
        end

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmr_fault_monitor.md
TMR_FAULT_MONITOR -- requirements
Module: tmr_fault_monitor

Interface
REQ-001 Parameter THRESH, 4, consecutive mismatching samples that declare a channel faulty (range 2..15).
REQ-002 Parameter CNT_W, 8, width of each per-channel total-mismatch counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  sample strobe; channels and vote are evaluated only in cycles where en=1.
REQ-006 clr  input  1  synchronous clear of all fault state and counters.
REQ-007 x2, x1, x0  input  1 each  raw redundant channels, the same three bits applied to the upstream voter.
REQ-008 y  input  1  voted result produced by the upstream voter from x2, x1, x0.
REQ-009 y_q  output  1  registered voted value.
REQ-010 fault  output  3  per-channel sticky fault flag; bit i corresponds to xi.
REQ-011 err_cnt2, err_cnt1, err_cnt0  output  CNT_W each  saturating total-mismatch counts per channel.
REQ-012 alarm  output  1  two or more channels faulty; the vote is no longer trustworthy.
REQ-013 voter_err  output  1  sticky flag; y disagreed with the majority of x2, x1, x0.

Function
REQ-014 Mismatch of channel i SHALL be defined as en=1 and xi != y in the same cycle.
REQ-015 Each channel SHALL run an independent three-state FSM: OK, SUSPECT, FAULTY.
REQ-016 OK: mismatch -> SUSPECT, consecutive count = 1; no mismatch -> stay OK.
REQ-017 SUSPECT: mismatch -> increment consecutive count; on reaching THRESH -> FAULTY; en=1 with match -> OK, count = 0; en=0 -> hold state and count.
REQ-018 FAULTY SHALL be sticky and SHALL be left only by clr or reset.
REQ-019 fault[i] SHALL be 1 exactly when channel i is in FAULTY, registered, asserted the cycle after the THRESH-th consecutive mismatch edge.
REQ-020 err_cnti SHALL increment by 1 on every mismatch of channel i in any state, including FAULTY, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-021 alarm SHALL be the registered OR of all pairwise ANDs of the next-state fault bits, so it asserts in the same cycle as the second fault bit.
REQ-022 voter_err SHALL set the cycle after any en=1 cycle in which y != (x2&x1 | x2&x0 | x1&x0), and SHALL stay set until clr or reset.
REQ-023 y_q SHALL load y on every en=1 edge and hold otherwise (1-cycle latency); y_q SHALL NOT be affected by clr.
REQ-024 clr=1 SHALL, at the next edge, return all FSMs to OK and zero the consecutive counts, err_cnt*, fault, alarm and voter_err; clr has priority over a simultaneous mismatch, which is not counted.
REQ-025 en=0 SHALL freeze all state; input values in that cycle SHALL have no effect.
REQ-026 Simultaneous mismatches on several channels SHALL be processed independently in the same cycle.

Reset
REQ-027 rst_n=0 SHALL, asynchronously and without a clock, force y_q=0, fault=3'b000, all err_cnt*=0, alarm=0, voter_err=0, and all FSMs to OK with count 0.
REQ-028 Reset asserted mid-operation, including in SUSPECT or FAULTY, SHALL produce the same state as REQ-027; operation resumes on the first edge after rst_n rises.

Verification
REQ-029 x={1,1,0}, y=1, en=1 for 4 cycles -> fault=3'b001 after the 4th edge, err_cnt0=4, alarm=0, y_q=1.
REQ-030 x0 mismatches 3 cycles, 1 matching cycle, 3 more mismatches -> fault[0]=0, err_cnt0=6, channel 0 in SUSPECT.
REQ-031 fault[0] set, then x1 mismatches 4 consecutive cycles -> fault=3'b011 and alarm=1 on the same edge.
REQ-032 x={1,1,1}, y=0, en=1 for 1 cycle -> voter_err=1, err_cnt2/1/0=1 each; voter_err holds after inputs are corrected.
REQ-033 CNT_W=2, x0 mismatches 6 cycles -> err_cnt0 stops at 3; then clr together with a mismatch -> err_cnt0=0, fault=0 on the next edge.
REQ-034 rst_n pulsed low between edges while fault=3'b111 -> all outputs 0 immediately, before the next clock edge.
